// File: rtl/vgg_soc_pkg.sv
// Shared SoC definitions: lane geometry, serializer FSM states and the
// enabled-lane search helper.
package vgg_soc_pkg;

    localparam int LANES  = 8;
    localparam int LANE_W = 3;
    localparam int IDX_W  = LANE_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

    // Lowest set bit of mask at or above 'from'; returns LANES when none exists,
    // so the MSB of the result doubles as a "no more lanes" flag.
    function automatic logic [IDX_W-1:0] next_enabled(
        input logic [LANES-1:0] mask,
        input logic [IDX_W-1:0] from
    );
        logic [IDX_W-1:0] res;
        res = IDX_W'(LANES);
        for (int i = LANES - 1; i >= 0; i--) begin
            if (i >= int'(from) && mask[i]) begin
                res = IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux8.sv
// Eight-way word multiplexer; select values 8..15 produce zero.
module mux8 #(
    parameter int W = 64
) (
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    input  logic [W-1:0] d3_i,
    input  logic [W-1:0] d4_i,
    input  logic [W-1:0] d5_i,
    input  logic [W-1:0] d6_i,
    input  logic [W-1:0] d7_i,
    input  logic [3:0]   sel_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (sel_i)
            4'd0:    y_o = d0_i;
            4'd1:    y_o = d1_i;
            4'd2:    y_o = d2_i;
            4'd3:    y_o = d3_i;
            4'd4:    y_o = d4_i;
            4'd5:    y_o = d5_i;
            4'd6:    y_o = d6_i;
            4'd7:    y_o = d7_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/lane_serializer.sv
// Captures an 8-lane parallel group and emits it one lane per handshake.
// Optional LANE_MASK_EN: capture in_mask and skip lanes whose bit is clear.
module lane_serializer
    import vgg_soc_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] in_2,
    input  logic [DATA_W-1:0] in_3,
    input  logic [DATA_W-1:0] in_4,
    input  logic [DATA_W-1:0] in_5,
    input  logic [DATA_W-1:0] in_6,
    input  logic [DATA_W-1:0] in_7,
    input  logic [DATA_W-1:0] in_8,
    input  logic [7:0]        in_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LANE_W-1:0] out_lane,
    output logic              out_last
);

    ser_state_e        state_q, state_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [DATA_W-1:0] bank_q [LANES];
    logic [DATA_W-1:0] in_words [LANES];
    logic [LANES-1:0]  accept_mask;
    logic [LANES-1:0]  active_mask;
    logic [IDX_W-1:0]  first_idx;
    logic [IDX_W-1:0]  next_idx;
    logic              accept;

    assign in_words = '{in_1, in_2, in_3, in_4, in_5, in_6, in_7, in_8};
    assign accept   = in_valid && in_ready;

`ifdef LANE_MASK_EN
    logic [LANES-1:0] mask_q;

    assign accept_mask = in_mask;
    assign active_mask = mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= in_mask;
        end
    end
`else
    logic unused_mask;

    assign accept_mask = '1;
    assign active_mask = '1;
    assign unused_mask = ^in_mask;
`endif

    assign first_idx = next_enabled(accept_mask, '0);
    assign next_idx  = next_enabled(active_mask, {1'b0, lane_q} + IDX_W'(1));

    // Bank is only written on accept, so its contents survive the whole SEND phase.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                bank_q[i] <= in_words[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                // An all-zero mask leaves first_idx flagged as empty: group is dropped.
                if (in_valid && !first_idx[IDX_W-1]) begin
                    state_d = ST_SEND;
                    lane_d  = first_idx[LANE_W-1:0];
                end
            end
            ST_SEND: begin
                out_valid = 1'b1;
                out_last  = next_idx[IDX_W-1];
                if (out_ready) begin
                    if (out_last) begin
                        state_d = ST_IDLE;
                        lane_d  = '0;
                    end else begin
                        lane_d = next_idx[LANE_W-1:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                lane_d  = '0;
            end
        endcase
    end

    assign out_lane = lane_q;

    mux8 #(
        .W(DATA_W)
    ) u_out_mux (
        .d0_i (bank_q[0]),
        .d1_i (bank_q[1]),
        .d2_i (bank_q[2]),
        .d3_i (bank_q[3]),
        .d4_i (bank_q[4]),
        .d5_i (bank_q[5]),
        .d6_i (bank_q[6]),
        .d7_i (bank_q[7]),
        .sel_i({1'b0, lane_q}),
        .y_o  (out_data)
    );

endmodule
